// File: rtl/add_arbiter_pkg.sv
// Shared types and constants for the add/sub round-robin arbiter.
// The FSM walks IDLE -> ISSUE -> WAIT -> RESP, with one operation in flight.
package add_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/add_arbiter_rr_picker.sv
// Combinational round-robin picker: the first asserted request found by searching
// upward from last_grant+1, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any_req
);

  localparam int SW = ID_WIDTH + 1;

  logic [ID_WIDTH-1:0] cand [NUM_REQ];
  logic [NUM_REQ-1:0]  hit;

  // cand[gi] is the requester index that sits gi+1 positions after last_grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [SW-1:0] sum;
    assign sum      = {1'b0, last_grant} + SW'(gi + 1);
    assign cand[gi] = (sum >= SW'(NUM_REQ)) ? ID_WIDTH'(sum - SW'(NUM_REQ))
                                            : sum[ID_WIDTH-1:0];
    assign hit[gi]  = req[cand[gi]];
  end

  always_comb begin
    grant   = '0;
    winner  = '0;
    any_req = |hit;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) winner = cand[k];
    end
    if (any_req) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter that time-shares one registered add/sub unit between
// NUM_REQ requesters and returns each result tagged with the requester ID.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_op,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_arg1,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_arg2,
  output logic                                alu_op_type,
  output logic [DATA_WIDTH-1:0]               alu_arg1,
  output logic [DATA_WIDTH-1:0]               alu_arg2,
  input  logic [DATA_WIDTH-1:0]               alu_res,
  input  logic                                alu_ov,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [ID_WIDTH-1:0]                 rsp_id,
  output logic [DATA_WIDTH-1:0]               rsp_res,
  output logic                                rsp_ov
);

  state_t              state_reg, state_next;
  logic [ID_WIDTH-1:0] last_grant_reg;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] winner;
  logic                any_req;
  logic                accept;

  rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Grants only happen in IDLE, and never while reset is held.
  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!reset && any_req) begin
          req_ready  = grant;
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= ID_WIDTH'(NUM_REQ - 1);
      alu_op_type    <= 1'b0;
      alu_arg1       <= '0;
      alu_arg2       <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_res        <= '0;
      rsp_ov         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        alu_op_type    <= req_op[winner];
        alu_arg1       <= req_arg1[winner];
        alu_arg2       <= req_arg2[winner];
        rsp_id         <= winner;
        last_grant_reg <= winner;
      end
      // The unit's overflow flag is only meaningful for adds; subs report 0.
      if (state_reg == WAIT) begin
        rsp_res   <= alu_res;
        rsp_ov    <= (alu_op_type == OP_ADD) && alu_ov;
        rsp_valid <= 1'b1;
      end
      if (state_reg == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Round-robin scheduler that shares one registered add/sub unit between NUM_REQ requesters.
- The unit has 1-cycle latency, op_type 1 = add, 0 = sub, and ov is meaningful for add only.
- Each requester presents an operation over a valid/ready handshake. The arbiter issues it to the unit, captures the result, and returns it on a single response channel tagged with the requester ID.
- Sits between client blocks and the add unit in the datapath top level.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the add unit.
- NUM_REQ, 4, number of requesters, 2..16.
- ID_WIDTH, $clog2(NUM_REQ), derived; width of requester ID.

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operation valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  input  NUM_REQ  per-requester op type, 1 = add, 0 = sub.
- req_arg1  input  NUM_REQ x DATA_WIDTH  per-requester first operand.
- req_arg2  input  NUM_REQ x DATA_WIDTH  per-requester second operand.
- alu_op_type  output  1  op type to shared unit.
- alu_arg1  output  DATA_WIDTH  operand 1 to shared unit.
- alu_arg2  output  DATA_WIDTH  operand 2 to shared unit.
- alu_res  input  DATA_WIDTH  registered result from unit.
- alu_ov  input  1  registered overflow/carry from unit.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_WIDTH  requester index of response.
- rsp_res  output  DATA_WIDTH  result.
- rsp_ov  output  1  carry-out (add), 0 for sub.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. One operation outstanding at a time.
- Reset values: state IDLE, last_grant = NUM_REQ-1 (so req 0 wins first), alu_op_type/alu_arg1/alu_arg2 = 0, rsp_valid/rsp_id/rsp_res/rsp_ov = 0.
- req_ready is forced 0 while reset is high.
- IDLE:
  - Winner = first asserted req_valid searching from last_grant+1 upward, modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally in the same cycle; all other bits 0.
  - On that edge, latch req_op/req_arg1/req_arg2[winner] into the alu_* registers, winner into the id register, set last_grant = winner, then go to ISSUE.
  - If no req_valid is asserted: stay in IDLE, req_ready = 0.
- ISSUE: alu_* stable for this cycle; the unit samples them at the end of the cycle. Then go to WAIT.
- WAIT: alu_res/alu_ov are valid in this cycle. Capture them into rsp_res/rsp_ov and set rsp_valid = 1 on the edge. Then go to RESP.
- RESP:
  - rsp_valid = 1. rsp_id/rsp_res/rsp_ov are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
  - The next grant happens in the following IDLE cycle, so there is no same-cycle accept/complete.
- Latency and throughput:
  - Accept edge to rsp_valid high: 3 cycles.
  - Peak throughput: 1 op per 4 cycles with rsp_ready held high.
- req_ready is asserted only in IDLE; req_* are don't-care in all other states.
- alu_* hold their last value outside ISSUE. No ALU reset is driven by this block.
- Arithmetic: no width changes; results pass through unmodified.
- Boundary conditions:
  - Fairness: with all requesters valid, grants rotate 0,1,2,3,0...
  - A requester dropping valid before it is granted is simply skipped.
  - Wrap: last_grant = NUM_REQ-1 searches from 0.
  - Reset in any state returns to IDLE next cycle. The in-flight result is discarded, with no rsp_valid pulse.
  - Reset concurrent with an accept: reset wins, req_ready stays 0, no transaction.
  - rsp_ready held low: the FSM stalls in RESP indefinitely, and no new grants are issued.

Decomposition:
- Package add_arbiter_pkg holds:
  - the state_t enum {IDLE, ISSUE, WAIT, RESP};
  - constants OP_ADD = 1'b1 and OP_SUB = 1'b0.
- Width-dependent types stay as module parameter types.
- One sub-module, rr_picker: combinational round-robin. Inputs are the request vector and last_grant; outputs are a one-hot grant, the winner index and an any-request flag. It is parameterised by NUM_REQ.

Test Plan:
- Single add: req 0, op 1, 5 + 7, rsp_ready = 1 → req_ready[0] pulses 1 cycle; 3 cycles later rsp_valid = 1, rsp_id = 0, rsp_res = 12, rsp_ov = 0.
- Sub and overflow (DATA_WIDTH 32):
  - req 2, op 0, 3 - 5 → rsp_res = 32'hFFFFFFFE, rsp_ov = 0, rsp_id = 2.
  - req 1, op 1, 32'hFFFFFFFF + 1 → rsp_res = 0, rsp_ov = 1.
- Fairness: all 4 req_valid held high, rsp_ready = 1 → rsp_id sequence 0,1,2,3,0,1; grants 4 cycles apart.
- Backpressure: rsp_ready = 0 for 10 cycles after rsp_valid → rsp fields stable, req_ready stays 0; rsp_ready = 1 → handshake, next grant 1 cycle later.
- Reset mid-op: assert reset in WAIT → no rsp_valid; after release, req 3 valid → granted, and rsp_id = 3 since last_grant was reset.
- Skip: req 1 and 3 valid, last_grant = 1 → req 3 granted before req 1.
